// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Generic pipeline stage register for an in-order CPU pipeline.
//                Captures a payload word, a control bundle and a valid bit
//                from the upstream stage on every rising clock edge. The
//                hazard unit can override the normal load with these
//                controls, listed from highest to lowest priority:
//                  flush  - clear payload, insert CTRL_NOP, drop valid
//                  stall  - hold all contents
//                  bubble - load payload, insert CTRL_NOP, drop valid
//                All outputs come straight from flops.
//
//  Ports       : clk        - rising-edge clock
//                reset      - asynchronous active-high reset
//                in_valid   - upstream holds a real instruction
//                data_in    - upstream payload (DATA_W)
//                ctrl_in    - upstream control bundle (CTRL_W)
//                stall      - hold contents this cycle
//                bubble     - load-use hazard, insert a NOP
//                flush      - branch/jump kill
//                data_out   - registered payload
//                ctrl_out   - registered control bundle
//                out_valid  - registered valid
//                stat_clr   - synchronous clear of the event counters
//                stall_cnt  - saturating count of effective stall edges
//                bubble_cnt - saturating count of inserted NOPs
//
//  Build option: define PIPE_STAT_EN to build in stat_clr, stall_cnt,
//                bubble_cnt and their counting logic. Without it the stage
//                register behaves identically but has no counters.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 24,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              stall,
    input  logic              bubble,
    input  logic              flush,
    output logic [DATA_W-1:0] data_out,
    output logic [CTRL_W-1:0] ctrl_out,
`ifdef PIPE_STAT_EN
    output logic              out_valid,
    input  logic              stat_clr,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt
`else
    output logic              out_valid
`endif
);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic              valid_d;
    logic              valid_q;

    // Next-state selection. Flush wins over everything, so a stalled stage
    // that is being killed still clears. While stalled the bubble request
    // is dropped; the hazard unit keeps asserting it until it takes effect.
    always_comb begin
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (flush) begin
            data_d  = '0;
            ctrl_d  = CTRL_NOP;
            valid_d = 1'b0;
        end else if (stall) begin
            data_d  = data_q;
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
        end else if (bubble) begin
            // Payload still moves forward so the downstream stage sees a
            // well-defined word, but the control is neutralised.
            data_d  = data_in;
            ctrl_d  = CTRL_NOP;
            valid_d = 1'b0;
        end else begin
            data_d  = data_in;
            ctrl_d  = in_valid ? ctrl_in : CTRL_NOP;
            valid_d = in_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            ctrl_q  <= CTRL_NOP;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign ctrl_out  = ctrl_q;
    assign out_valid = valid_q;

`ifdef PIPE_STAT_EN
    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic        stall_evt;
    logic        bubble_evt;
    logic [15:0] stall_cnt_d;
    logic [15:0] stall_cnt_q;
    logic [15:0] bubble_cnt_d;
    logic [15:0] bubble_cnt_q;

    // A stall only counts when it actually holds the stage. A NOP is
    // inserted either by a flush or by a bubble that was not overridden
    // by a stall.
    assign stall_evt  = stall & ~flush;
    assign bubble_evt = flush | (bubble & ~stall);

    // Clear has precedence over an increment on the same edge; counters
    // stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stat_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (stall_evt && (stall_cnt_q != c_cnt_max)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (bubble_evt && (bubble_cnt_q != c_cnt_max)) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. A behavioural model
//                tracks the expected stage contents; a compare process
//                checks the DUT against it on every falling edge, and
//                directed vectors add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 24;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data_in  = '0;
    logic [CW-1:0] ctrl_in  = '0;
    logic          stall    = 1'b0;
    logic          bubble   = 1'b0;
    logic          flush    = 1'b0;
    logic          stat_clr = 1'b0;
    logic [DW-1:0] data_out;
    logic [CW-1:0] ctrl_out;
    logic          out_valid;
    logic [15:0]   stall_cnt;
    logic [15:0]   bubble_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .ctrl_in    (ctrl_in),
        .stall      (stall),
        .bubble     (bubble),
        .flush      (flush),
        .data_out   (data_out),
        .ctrl_out   (ctrl_out),
`ifdef PIPE_STAT_EN
        .out_valid  (out_valid),
        .stat_clr   (stat_clr),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`else
        .out_valid  (out_valid)
`endif
    );

`ifndef PIPE_STAT_EN
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what the stage must hold after each edge.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_ctrl;
    logic          m_valid;
    int            m_scnt;
    int            m_bcnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data = '0; m_ctrl = '0; m_valid = 1'b0; m_scnt = 0; m_bcnt = 0;
        end else begin
            // counters: clear overrides, saturate at 65535
            if (stat_clr) begin
                m_scnt = 0; m_bcnt = 0;
            end else begin
                if (stall && !flush)             m_scnt = (m_scnt < 65535) ? m_scnt + 1 : 65535;
                if (flush || (bubble && !stall)) m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : 65535;
            end
            if (flush) begin
                m_data = '0; m_ctrl = '0; m_valid = 1'b0;
            end else if (!stall) begin
                m_data  = data_in;
                m_valid = in_valid && !bubble;
                m_ctrl  = m_valid ? ctrl_in : '0;
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_data",  data_out,  m_data);
            chk("model_ctrl",  ctrl_out,  m_ctrl);
            chk("model_valid", out_valid, m_valid);
`ifdef PIPE_STAT_EN
            chk("model_scnt",  stall_cnt,  m_scnt[15:0]);
            chk("model_bcnt",  bubble_cnt, m_bcnt[15:0]);
`endif
        end
    end

    // Drive inputs, then advance through one rising edge; returns 1 time
    // unit after the edge so outputs can be inspected.
    task automatic apply(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic st, input logic bu, input logic fl);
        in_valid = v; data_in = d; ctrl_in = c; stall = st; bubble = bu; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [DW-1:0] d,
                           input logic [CW-1:0] c, input logic v);
        chk({name, "_data"},  data_out,  d);
        chk({name, "_ctrl"},  ctrl_out,  c);
        chk({name, "_valid"}, out_valid, v);
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk_out("reset", '0, '0, 1'b0);
`ifdef PIPE_STAT_EN
        chk("reset_scnt", stall_cnt, 16'h0);
        chk("reset_bcnt", bubble_cnt, 16'h0);
`endif
        // inputs ignored while reset is high
        apply(1'b1, 32'hFFFF_FFFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        chk_out("reset_hold", '0, '0, 1'b0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // load
        apply(1'b1, 32'h0040_0008, 24'h00A5C3, 1'b0, 1'b0, 1'b0);
        chk_out("load", 32'h0040_0008, 24'h00A5C3, 1'b1);

        // stall for three edges, then release
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'hDEAD_BEEF, 24'h111111, 1'b1, 1'b0, 1'b0);
            chk_out("stall_hold", 32'h0040_0008, 24'h00A5C3, 1'b1);
        end
        apply(1'b1, 32'hDEAD_BEEF, 24'h111111, 1'b0, 1'b0, 1'b0);
        chk_out("stall_release", 32'hDEAD_BEEF, 24'h111111, 1'b1);
`ifdef PIPE_STAT_EN
        chk("stall_cnt3", stall_cnt, 16'd3);
`endif

        // bubble
        apply(1'b1, 32'h1234_5678, 24'hFFFFFF, 1'b0, 1'b1, 1'b0);
        chk_out("bubble", 32'h1234_5678, 24'h0, 1'b0);
`ifdef PIPE_STAT_EN
        chk("bubble_cnt1", bubble_cnt, 16'd1);
`endif

        // load, then stall+bubble: bubble ignored, contents held
        apply(1'b1, 32'h0000_00C4, 24'h000777, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 32'hAAAA_5555, 24'h222222, 1'b1, 1'b1, 1'b0);
        chk_out("stall_bubble", 32'h0000_00C4, 24'h000777, 1'b1);

        // flush+stall+bubble
        apply(1'b1, 32'hAAAA_5555, 24'h222222, 1'b1, 1'b1, 1'b1);
        chk_out("flush_all", '0, '0, 1'b0);
`ifdef PIPE_STAT_EN
        chk("flush_scnt", stall_cnt, 16'd4);
        chk("flush_bcnt", bubble_cnt, 16'd2);
`endif

        // invalid load inserts NOP control
        apply(1'b0, 32'h0000_0055, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
        chk_out("invalid_load", 32'h0000_0055, 24'h0, 1'b0);

        // back-to-back loads with assorted patterns
        apply(1'b1, 32'h8000_0001, 24'h800001, 1'b0, 1'b0, 1'b0);
        chk_out("load_a", 32'h8000_0001, 24'h800001, 1'b1);
        apply(1'b1, 32'h0F0F_F0F0, 24'h5A5A5A, 1'b0, 1'b0, 1'b0);
        chk_out("load_b", 32'h0F0F_F0F0, 24'h5A5A5A, 1'b1);
        for (int i = 0; i < 8; i++)
            apply(1'($urandom_range(1)), $urandom, 24'($urandom),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(3) == 0));

`ifdef PIPE_STAT_EN
        // clear overrides a same-edge increment
        stat_clr = 1'b1;
        apply(1'b1, 32'h1, 24'h1, 1'b1, 1'b0, 1'b0);
        stat_clr = 1'b0;
        chk("clr_scnt", stall_cnt, 16'd0);
        chk("clr_bcnt", bubble_cnt, 16'd0);
`endif

        // reset asserted mid-stall discards held contents, no edge needed
        apply(1'b1, 32'h0BAD_CAFE, 24'h0C0FFE, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 32'h0000_0001, 24'h000001, 1'b1, 1'b0, 1'b0);
        chk_out("pre_rst", 32'h0BAD_CAFE, 24'h0C0FFE, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk_out("async_rst", '0, '0, 1'b0);
        #1 reset = 1'b0;
        // stall still asserted: first edge after reset holds the reset values
        apply(1'b1, 32'h0000_0001, 24'h000001, 1'b1, 1'b0, 1'b0);
        chk_out("post_rst_stall", '0, '0, 1'b0);
        apply(1'b1, 32'h0000_0002, 24'h000002, 1'b0, 1'b0, 1'b0);
        chk_out("post_rst_load", 32'h2, 24'h2, 1'b1);

`ifdef PIPE_STAT_EN
        // bring bubble_cnt to FFFE, then three more bubbles saturate it
        for (int i = 0; i < 65534; i++)
            apply(1'b1, i, 24'h3, 1'b0, 1'b1, 1'b0);
        chk("bcnt_fffe", bubble_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'h77, 24'h3, 1'b0, 1'b1, 1'b0);
            chk("bcnt_sat", bubble_cnt, 16'hFFFF);
        end
        #1 reset = 1'b1;
        #1;
        chk_out("sat_rst", '0, '0, 1'b0);
        chk("sat_rst_bcnt", bubble_cnt, 16'h0);
        chk("sat_rst_scnt", stall_cnt, 16'h0);
        #1 reset = 1'b0;
`endif

        apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
